// File: rtl/tape_ram_writer.sv
// tape_ram_writer: buffers cassette-parser bytes in a small FIFO, commits them
// to main RAM only in bus-free cycles, then hands the autostart address to the
// machine-control logic through a valid/ack handshake.
module tape_ram_writer #(
    parameter int FIFO_AW     = 4,
    parameter int WAIT_MARGIN = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tape_wr,
    input  logic [15:0] tape_addr,
    input  logic [7:0]  tape_dout,
    input  logic        tape_complete,
    input  logic        bus_free,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ioctl_wait,
    output logic        overflow,
    output logic        busy,
    output logic        exec_valid,
    output logic [15:0] exec_addr,
    input  logic        exec_ack
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   FULL_COUNT = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]   WAIT_LEVEL = FULL_COUNT - (FIFO_AW + 1)'(WAIT_MARGIN);
    localparam logic [FIFO_AW:0]   CNT_ONE    = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW-1:0] PTR_ONE    = {{(FIFO_AW - 1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [23:0]          mem_q [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]     count_q, count_d;
    logic                 prev_wr_q;
    logic [15:0]          prev_addr_q;
    logic                 prev_complete_q;
    logic                 exec_pending_q, exec_pending_d;
    logic [15:0]          exec_addr_q, exec_addr_d;
    logic                 overflow_q, overflow_d;
    logic                 ram_we_q, ram_we_d;
    logic [15:0]          ram_addr_q, ram_addr_d;
    logic [7:0]           ram_din_q, ram_din_d;
    logic                 ioctl_wait_q;

    logic                 capture;
    logic                 push;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_nonempty;
    logic                 complete_rise;
    logic [23:0]          head;

    // Capture detection: a new byte is a rising write level or an address step.
    always_comb begin
        capture       = tape_wr && !tape_complete &&
                        (!prev_wr_q || (tape_addr != prev_addr_q));
        fifo_full     = (count_q == FULL_COUNT);
        fifo_nonempty = (count_q != '0);
        push          = capture && !fifo_full;
        complete_rise = tape_complete && !prev_complete_q;
        head          = mem_q[rd_ptr_q];
    end

    // FSM next state, pop decision and RAM write port / exec bookkeeping.
    always_comb begin
        state_d        = state_q;
        pop            = 1'b0;
        ram_we_d       = 1'b0;
        ram_addr_d     = ram_addr_q;
        ram_din_d      = ram_din_q;
        exec_pending_d = exec_pending_q;
        exec_addr_d    = exec_addr_q;
        unique case (state_q)
            IDLE, WRITE: begin
                if (fifo_nonempty && bus_free) begin
                    pop        = 1'b1;
                    ram_we_d   = 1'b1;
                    ram_addr_d = head[23:8];
                    ram_din_d  = head[7:0];
                    state_d    = WRITE;
                end else if (exec_pending_q && !fifo_nonempty && !capture && !complete_rise) begin
                    // Do not enter EXEC while a byte or a newer exec address is landing.
                    state_d = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                if (capture || complete_rise || exec_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (complete_rise) begin
            exec_pending_d = 1'b1;
            exec_addr_d    = tape_addr;
        end else if ((state_q == EXEC) && exec_ack) begin
            exec_pending_d = 1'b0;
        end
    end

    // FIFO pointer, occupancy and overflow next-state.
    always_comb begin
        wr_ptr_d   = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d   = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q || (capture && fifo_full);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents need no reset since occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {tape_addr, tape_dout};
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            prev_wr_q       <= 1'b0;
            prev_addr_q     <= '0;
            prev_complete_q <= 1'b0;
            exec_pending_q  <= 1'b0;
            exec_addr_q     <= '0;
            overflow_q      <= 1'b0;
            ram_we_q        <= 1'b0;
            ram_addr_q      <= '0;
            ram_din_q       <= '0;
            ioctl_wait_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            prev_wr_q       <= tape_wr;
            prev_addr_q     <= tape_addr;
            prev_complete_q <= tape_complete;
            exec_pending_q  <= exec_pending_d;
            exec_addr_q     <= exec_addr_d;
            overflow_q      <= overflow_d;
            ram_we_q        <= ram_we_d;
            ram_addr_q      <= ram_addr_d;
            ram_din_q       <= ram_din_d;
            ioctl_wait_q    <= (count_d >= WAIT_LEVEL);
        end
    end

    // Output drive.
    always_comb begin
        ram_we     = ram_we_q;
        ram_addr   = ram_addr_q;
        ram_din    = ram_din_q;
        ioctl_wait = ioctl_wait_q;
        overflow   = overflow_q;
        exec_valid = (state_q == EXEC);
        exec_addr  = exec_addr_q;
        busy       = fifo_nonempty || (state_q != IDLE) || exec_pending_q;
    end

endmodule

// File: tb/tb_tape_ram_writer.sv
// Scoreboard bench for tape_ram_writer: stimulus pushes expected RAM writes and
// exec addresses into queues; a negedge monitor pops and compares them.
module tb_tape_ram_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        tape_wr;
    logic [15:0] tape_addr;
    logic [7:0]  tape_dout;
    logic        tape_complete;
    logic        bus_free;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ioctl_wait;
    logic        overflow;
    logic        busy;
    logic        exec_valid;
    logic [15:0] exec_addr;
    logic        exec_ack;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned wr_seen = 0;

    logic [23:0] exp_wr_q[$];
    logic [15:0] exp_exec_q[$];

    tape_ram_writer #(.FIFO_AW(4), .WAIT_MARGIN(2)) dut (
        .clk(clk), .reset(reset), .tape_wr(tape_wr), .tape_addr(tape_addr),
        .tape_dout(tape_dout), .tape_complete(tape_complete), .bus_free(bus_free),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ioctl_wait(ioctl_wait), .overflow(overflow), .busy(busy),
        .exec_valid(exec_valid), .exec_addr(exec_addr), .exec_ack(exec_ack)
    );

    always #5 clk = ~clk;

    // Monitor: every RAM write and every exec_valid rise is checked against the queues.
    logic exec_prev = 1'b0;
    always @(negedge clk) begin
        logic [23:0] e;
        if (reset) begin
            exec_prev = 1'b0;
        end else begin
            if (ram_we) begin
                wr_seen++;
                checks++;
                if (exp_wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got addr %h data %h, required no write", ram_addr, ram_din);
                end else begin
                    e = exp_wr_q.pop_front();
                    if ({ram_addr, ram_din} !== e) begin
                        errors++;
                        $display("FAIL write_data: got %h/%h required %h/%h", ram_addr, ram_din, e[23:8], e[7:0]);
                    end
                end
            end
            if (exec_valid && !exec_prev) begin
                checks++;
                if (exp_exec_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_exec: got exec_addr %h, required no exec_valid", exec_addr);
                end else if (exec_addr !== exp_exec_q[0] || exp_wr_q.size() != 0) begin
                    errors++;
                    $display("FAIL exec_order: got addr %h with %0d writes left, required %h with 0",
                             exec_addr, exp_wr_q.size(), exp_exec_q[0]);
                    void'(exp_exec_q.pop_front());
                end else begin
                    void'(exp_exec_q.pop_front());
                end
            end
            exec_prev = exec_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    // Present one byte for 'hold' cycles; expected writes are queued only for accepted bytes.
    task automatic send_byte(input logic [15:0] a, input logic [7:0] d, input int hold, input bit accepted);
        tape_wr   = 1'b1;
        tape_addr = a;
        tape_dout = d;
        if (accepted) exp_wr_q.push_back({a, d});
        repeat (hold) tick();
    endtask

    task automatic idle_wr();
        tape_wr = 1'b0;
    endtask

    initial begin : main
        int unsigned base;
        logic [7:0] pat;
        int bad;
        bit found;

        reset = 1'b1; tape_wr = 1'b0; tape_addr = '0; tape_dout = '0;
        tape_complete = 1'b0; bus_free = 1'b0; exec_ack = 1'b0;
        #1;
        tick(); tick();
        check("reset_ram_we", ram_we, 0);
        check("reset_ram_addr", ram_addr, 0);
        check("reset_ram_din", ram_din, 0);
        check("reset_ioctl_wait", ioctl_wait, 0);
        check("reset_overflow", overflow, 0);
        check("reset_busy", busy, 0);
        check("reset_exec_valid", exec_valid, 0);
        check("reset_exec_addr", exec_addr, 0);
        reset = 1'b0;
        tick();

        // Basic load, with latency: capture cycle N -> ram_we in N+2.
        bus_free = 1'b1;
        base = wr_seen;
        send_byte(16'h694D, 8'hA1, 1, 1'b1);
        check("latency_n1", ram_we, 0);
        tick();
        check("latency_n2", ram_we, 1);
        repeat (6) tick();
        send_byte(16'h694E, 8'hB2, 8, 1'b1);
        send_byte(16'h694F, 8'hC3, 8, 1'b1);
        send_byte(16'h6950, 8'hD4, 8, 1'b1);
        idle_wr();
        repeat (5) tick();
        check("basic_write_count", wr_seen - base, 4);
        check("basic_busy_idle", busy, 0);

        // Bus contention: nothing written while bus_free=0, then four back-to-back writes.
        bus_free = 1'b0;
        bad = 0;
        send_byte(16'h694D, 8'h11, 2, 1'b1);
        send_byte(16'h694E, 8'h22, 2, 1'b1);
        send_byte(16'h694F, 8'h33, 2, 1'b1);
        send_byte(16'h6950, 8'h44, 1, 1'b1);
        idle_wr();
        for (int i = 0; i < 13; i++) begin
            if (ram_we !== 1'b0 || busy !== 1'b1) bad++;
            tick();
        end
        check("contention_hold", bad, 0);
        bus_free = 1'b1;
        pat = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            pat = {pat[6:0], ram_we};
        end
        check("contention_b2b", pat, 8'b1111_0000);
        check("contention_busy_end", busy, 0);

        // Completion ordering: exec waits for the three queued writes.
        bus_free = 1'b0;
        send_byte(16'h6960, 8'h5A, 2, 1'b1);
        send_byte(16'h6961, 8'h5B, 2, 1'b1);
        send_byte(16'h6962, 8'h5C, 2, 1'b1);
        idle_wr();
        tape_complete = 1'b1;
        tape_addr = 16'h6A00;
        exp_exec_q.push_back(16'h6A00);
        repeat (3) tick();
        tape_complete = 1'b0;
        repeat (4) tick();
        check("exec_hold_while_busy", exec_valid, 0);
        check("busy_while_pending", busy, 1);
        bus_free = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = exec_valid;
        end
        check("exec_valid_seen", found, 1);
        check("exec_addr_value", exec_addr, 16'h6A00);
        tick();
        check("exec_valid_held", exec_valid, 1);
        exec_ack = 1'b1;
        tick();
        exec_ack = 1'b0;
        check("exec_after_ack", exec_valid, 0);
        check("busy_after_ack", busy, 0);

        // Overflow: 17 distinct bytes with the bus held; the 17th is dropped.
        bus_free = 1'b0;
        base = wr_seen;
        bad = 0;
        for (int i = 0; i < 17; i++) begin
            send_byte(16'h7000 + 16'(i), 8'(i * 3 + 1), 1, i < 16);
            if (ioctl_wait !== ((i + 1) >= 14)) bad++;
            if (overflow !== (i == 16)) bad++;
        end
        idle_wr();
        check("overflow_wait_profile", bad, 0);
        tick();
        check("overflow_sticky", overflow, 1);
        bus_free = 1'b1;
        repeat (30) tick();
        check("overflow_write_count", wr_seen - base, 16);
        check("overflow_still_set", overflow, 1);
        check("overflow_wait_clear", ioctl_wait, 0);

        // Wrap: 40 bytes with bus_free toggling in two-cycle phases.
        base = wr_seen;
        tape_wr = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tape_addr = 16'h8000 + 16'(i * 5);
            tape_dout = 8'(i * 7 + 3);
            exp_wr_q.push_back({tape_addr, tape_dout});
            for (int c = 0; c < 2; c++) begin
                bus_free = ((i * 2 + c) % 4) < 2;
                tick();
            end
        end
        idle_wr();
        bus_free = 1'b1;
        repeat (40) tick();
        check("wrap_write_count", wr_seen - base, 40);
        check("wrap_queue_drained", exp_wr_q.size(), 0);

        // Reset mid-load with an exec pending.
        bus_free = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(16'h9000 + 16'(i), 8'(8'hE0 + i), 1, 1'b1);
        idle_wr();
        tape_complete = 1'b1;
        tape_addr = 16'h9ABC;
        tick();
        tape_complete = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_wr_q.delete();
        exp_exec_q.delete();
        check("rst2_ram_we", ram_we, 0);
        check("rst2_ram_addr", ram_addr, 0);
        check("rst2_ram_din", ram_din, 0);
        check("rst2_ioctl_wait", ioctl_wait, 0);
        check("rst2_overflow", overflow, 0);
        check("rst2_busy", busy, 0);
        check("rst2_exec_valid", exec_valid, 0);
        check("rst2_exec_addr", exec_addr, 0);
        bus_free = 1'b1;
        base = wr_seen;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ram_we !== 1'b0 || exec_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("rst2_quiet", bad, 0);
        check("rst2_no_writes", wr_seen - base, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/tape_ram_writer.md
Name: tape_ram_writer

Overview:
- Downstream stage of the cassette parser: consumes its tape_wr/tape_addr/tape_dout byte stream and its tape_complete indication.
- Buffers bytes in a small FIFO and commits them to Lynx main RAM only in cycles where the CPU is not using the bus.
- Once all bytes are committed after a tape_complete, presents the execution/autostart address to the machine-control logic with a valid/ack handshake.

Parameters:
- FIFO_AW, 4, log2 of FIFO depth (depth = 16 entries of {addr[15:0], data[7:0]})
- WAIT_MARGIN, 2, ioctl_wait asserts when free entries <= WAIT_MARGIN

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tape_wr  in  1  byte-write level from cassette parser
- tape_addr  in  16  target RAM address, or exec address while tape_complete=1
- tape_dout  in  8  byte data
- tape_complete  in  1  load-finished indication
- bus_free  in  1  1 = CPU not accessing RAM this cycle
- ram_we  out  1  RAM write strobe, one cycle per byte
- ram_addr  out  16  RAM write address
- ram_din  out  8  RAM write data
- ioctl_wait  out  1  backpressure to the download source
- overflow  out  1  sticky: a byte was dropped
- busy  out  1  FIFO non-empty, write in flight, or exec pending
- exec_valid  out  1  exec_addr valid, held until acknowledged
- exec_addr  out  16  start address for autostart
- exec_ack  in  1  consumer accepted exec_addr

Behaviour:
- Clock is clk; reset is synchronous, active-high. All state updates on posedge clk.
- Reset values: ram_we=0, ram_addr=0, ram_din=0, ioctl_wait=0, overflow=0, busy=0, exec_valid=0, exec_addr=0. Reset also empties the FIFO, clears exec_pending, sets state IDLE and sets the registered prev_wr=0 / prev_addr=0.
- Reset mid-operation discards all queued bytes and any pending exec; no ram_we in the cycle after reset.
- Capture rule: tape_wr is a level held across many cycles. A byte is captured in cycle N when tape_wr=1 and tape_complete=0 and (prev_wr=0 or tape_addr != prev_addr). prev_wr and prev_addr register tape_wr and tape_addr every cycle.
- Push: each capture pushes {tape_addr, tape_dout}.
  - If FIFO is full, the byte is dropped and overflow is set; overflow stays set until reset.
  - Push and pop in the same cycle are both allowed; count is unchanged.
- Complete rule: on a tape_complete rising edge (prev_complete=0, tape_complete=1), latch exec_addr<=tape_addr and set exec_pending=1.
  - A second rising edge while pending or valid overwrites exec_addr (latest wins) and deasserts exec_valid until re-drained.
- FSM:
  - IDLE: if FIFO non-empty and bus_free=1, pop the head and go to WRITE. Else, if exec_pending and FIFO empty, go to EXEC.
  - WRITE: ram_we=1 for exactly one cycle with the popped addr/data. Next cycle, same decision as IDLE (back-to-back writes allowed when bus_free stays 1).
  - EXEC: exec_valid=1 and held. When exec_ack=1, exec_valid=0 and exec_pending=0 next cycle; return to IDLE.
    - A capture while in EXEC pushes normally. exec_valid drops and the FSM returns to IDLE to drain first, keeping exec_pending.
- Latency: a byte captured in cycle N, with FIFO empty and bus_free=1, produces ram_we=1 in cycle N+2.
- Never assert ram_we in a cycle where bus_free=0. The pop decision uses bus_free of the pop cycle, and the write cycle is guaranteed free because the Lynx arbiter holds bus_free for 2 cycles minimum.
- ioctl_wait = registered (count >= 2^FIFO_AW - WAIT_MARGIN).
- busy = (count != 0) or (state != IDLE) or exec_pending.
- Count width is FIFO_AW+1. Read/write pointers are FIFO_AW bits and wrap modulo depth.

Test Plan:
- Basic load: tape_wr=1, tape_addr steps 0x694D..0x6950 (4 bytes, each held 8 cycles), bus_free=1 -> exactly 4 ram_we pulses with addr 0x694D..0x6950 and matching data; no duplicates while addr is held.
- Bus contention: same 4 bytes, bus_free=0 for 20 cycles then 1 -> no ram_we while bus_free=0, then 4 back-to-back ram_we in order; busy=1 throughout.
- Completion ordering: 3 bytes queued with bus_free=0, then tape_complete pulse with tape_addr=0x6A00 -> exec_valid stays 0 until all 3 writes are done, then exec_valid=1, exec_addr=0x6A00; exec_ack=1 -> exec_valid=0 next cycle, busy=0.
- Overflow: bus_free=0, push 17 distinct addresses -> ioctl_wait=1 at count 14, 17th byte dropped, overflow=1; after bus_free=1, exactly 16 writes occur.
- Wrap: 40 bytes streamed with bus_free toggling 1/0 -> write order and data identical to input across pointer wrap.
- Reset mid-load: 5 bytes queued plus exec pending, reset for 1 cycle -> all outputs at reset values; no subsequent ram_we or exec_valid without new input.
